calc_result_serializer: RTL and testbench
=========================================

// Module: calc_result_serializer
// PURPOSE
//  Output end of the signed 2-bit calculator datapath. Captures a 5-bit two's-complement
//  answer and 3-bit remainder on a start strobe, converts the answer to sign-magnitude
//  form, and shifts it out as a fixed 12-bit framed word on one pin.
//  Sits between the calculator core and the chip output pins.
// PARAMETERS
//  BIT_CYCLES  1  clocks each frame bit is held on ser_out (>=1)
// PORTS
//  clk        in   1  system clock, all logic on rising edge
//  reset      in   1  synchronous, active-high reset
//  start      in   1  capture request, sampled only while busy=0
//  answer     in   5  calculator result, two's complement (-16..15)
//  remainder  in   3  calculator remainder, unsigned
//  is_div     in   1  1 = result came from a divide (opn==3); remainder is meaningful
//  ser_out    out  1  serial frame data, MSB-first
//  ser_valid  out  1  1 while ser_out carries a frame bit
//  busy       out  1  1 while a frame is in progress
//  done       out  1  one-cycle pulse after the last frame bit
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, capture registers 0. reset overrides start.
//  Capture (IDLE, start=1, cycle N): latch sign=answer[4];
//   mag=sign ? (~answer+5'd1) : answer, 5 bits (-16 -> 5'b10000);
//   rem=is_div ? remainder : 3'b000; par = ^{sign,mag,rem} (even parity).
//  Frame, 12 bits in order: 1 (start), sign, mag[4:0], rem[2:0], par, 0 (stop).
//  FSM: IDLE -> SEND (on accepted start) -> IDLE (after stop bit period).
//   SEND: bit index 0..11, and a hold counter 0..BIT_CYCLES-1. Index advances when the
//   hold counter wraps.
//  Timing: busy=1 and ser_valid=1 from cycle N+1 through N+12*BIT_CYCLES.
//   Frame bit k drives ser_out during cycles N+1+k*BIT_CYCLES .. N+(k+1)*BIT_CYCLES.
//   In cycle N+12*BIT_CYCLES+1: done=1, busy=0, ser_valid=0, ser_out=0.
//  start while busy=1: ignored. No queuing; inputs are not re-sampled.
//  start in the done cycle: accepted. The new frame begins next cycle, giving
//   back-to-back frames with a single idle cycle.
//  Inputs are sampled only in the capture cycle. Later changes do not affect the frame.
//  Idle: ser_out=0, ser_valid=0.
//  reset mid-frame: in the next cycle all outputs are 0 and the state is IDLE.
//   The partial frame is abandoned and done is not pulsed.
//  All outputs are registered. There is no combinational path from any input to any output.
// TESTING
//  T1 BIT_CYCLES=1, answer=5'b11101 (-3), remainder=3'd2, is_div=1, start pulse
//     -> ser_out 1,1,0,0,0,1,1,0,1,0,0,0 over cycles N+1..N+12; done at N+13.
//  T2 answer=5'b10000 (-16), is_div=0 -> sign=1, mag=10000, rem=000, par=0;
//     frame 1,1,1,0,0,0,0,0,0,0,0,0.
//  T3 answer=5'd7, remainder=3'b111, is_div=0 -> rem bits 000, par=1;
//     frame 1,0,0,0,1,1,1,0,0,0,1,0.
//  T4 start held high continuously -> frames repeat every 13 cycles.
//     Extra start pulses mid-frame do not alter the frame or its timing.
//  T5 BIT_CYCLES=3, T1 stimulus -> each bit held exactly 3 cycles;
//     busy for 36 cycles; done at N+37.
//  T6 reset asserted at frame bit 5 -> next cycle busy=ser_valid=ser_out=done=0.
//     No done pulse follows. A fresh start then produces a complete correct frame.

Source files
------------

// File: rtl/calc_result_serializer.sv
// Captures a signed calculator answer plus remainder, converts it to sign-magnitude,
// and shifts it out MSB-first as a 12-bit framed word on one pin.
//
// state | meaning
// IDLE  | waiting for start; outputs low except a one-cycle done after a frame
// SEND  | frame in progress; bit_idx selects the frame bit, hold paces each bit
module calc_result_serializer #(
    parameter int BIT_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [4:0] answer,
    input  logic [2:0] remainder,
    input  logic       is_div,
    output logic       ser_out,
    output logic       ser_valid,
    output logic       busy,
    output logic       done
);

    localparam int HW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(BIT_CYCLES - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t          state;
    logic [10:0]     shift_q;
    logic [3:0]      bit_idx;
    logic [HW-1:0]   hold;

    logic            sign_in;
    logic [4:0]      mag_in;
    logic [2:0]      rem_in;
    logic            par_in;

    always_comb begin
        sign_in = answer[4];
        mag_in  = sign_in ? (~answer + 5'd1) : answer;
        rem_in  = is_div ? remainder : 3'b000;
        par_in  = ^{sign_in, mag_in, rem_in};
    end

    // shift_q holds the frame after the start bit, which is driven directly at capture
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            shift_q   <= '0;
            bit_idx   <= '0;
            hold      <= '0;
            ser_out   <= 1'b0;
            ser_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done      <= 1'b0;
                    ser_out   <= 1'b0;
                    ser_valid <= 1'b0;
                    busy      <= 1'b0;
                    if (start) begin
                        state     <= SEND;
                        shift_q   <= {sign_in, mag_in, rem_in, par_in, 1'b0};
                        bit_idx   <= '0;
                        hold      <= '0;
                        ser_out   <= 1'b1;
                        ser_valid <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                SEND: begin
                    if (hold == HOLD_LAST) begin
                        hold <= '0;
                        if (bit_idx == 4'd11) begin
                            state     <= IDLE;
                            ser_out   <= 1'b0;
                            ser_valid <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 4'd1;
                            ser_out <= shift_q[10];
                            shift_q <= {shift_q[9:0], 1'b0};
                        end
                    end else begin
                        hold <= hold + HW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_calc_result_serializer.sv
// Scoreboard bench: two serializers (1 and 3 clocks per bit) driven with directed and
// random stimulus; a negedge monitor rebuilds each frame and compares it to the model.
module tb_calc_result_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       start_v [2];
    logic       reset_v [2];
    logic       is_div_v[2];
    logic [4:0] answer_v[2];
    logic [2:0] rem_v   [2];
    logic       ser_out_v[2];
    logic       ser_valid_v[2];
    logic       busy_v[2];
    logic       done_v[2];

    calc_result_serializer #(.BIT_CYCLES(1)) dut_bc1 (
        .clk(clk), .reset(reset_v[0]), .start(start_v[0]), .answer(answer_v[0]),
        .remainder(rem_v[0]), .is_div(is_div_v[0]), .ser_out(ser_out_v[0]),
        .ser_valid(ser_valid_v[0]), .busy(busy_v[0]), .done(done_v[0]));

    calc_result_serializer #(.BIT_CYCLES(3)) dut_bc3 (
        .clk(clk), .reset(reset_v[1]), .start(start_v[1]), .answer(answer_v[1]),
        .remainder(rem_v[1]), .is_div(is_div_v[1]), .ser_out(ser_out_v[1]),
        .ser_valid(ser_valid_v[1]), .busy(busy_v[1]), .done(done_v[1]));

    int   cyc = 0;
    int   passed = 0;
    int   total = 0;
    logic rst_q[2];
    logic fin[2];

    // expected frames, written by the drivers and consumed in order by the monitor
    logic [11:0] exp_bits[2][512];
    int          exp_cyc [2][512];
    int          wr[2];
    int          rd[2];
    int          remaining[2];

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_q[0] <= reset_v[0];
        rst_q[1] <= reset_v[1];
    end

    function automatic int bc(int l);
        return (l == 0) ? 1 : 3;
    endfunction

    function automatic logic [11:0] frame_of(logic [4:0] a, logic [2:0] r, logic d);
        int         v;
        int         m;
        logic       s;
        logic [4:0] mg;
        logic [2:0] rr;
        logic       p;
        v  = $signed(a);
        s  = (v < 0);
        m  = s ? -v : v;
        mg = m[4:0];
        rr = d ? r : 3'b000;
        p  = ^{s, mg, rr};
        return {1'b1, s, mg, rr, p, 1'b0};
    endfunction

    task automatic chk(int l, string nm, logic [31:0] got, logic [31:0] want);
        total++;
        if (got === want) passed++;
        else $display("FAIL lane%0d %s got=%0h want=%0h cyc=%0d", l, nm, got, want, cyc);
    endtask

    // one clock of stimulus; the model consumes exactly what the DUT sampled at the edge
    task automatic step(int l);
        logic s, rs, d;
        logic [4:0] a;
        logic [2:0] r;
        s  = start_v[l];
        rs = reset_v[l];
        d  = is_div_v[l];
        a  = answer_v[l];
        r  = rem_v[l];
        @(posedge clk);
        #1;
        if (rs) remaining[l] = 0;
        else if (remaining[l] > 0) remaining[l]--;
        else if (s) begin
            if (wr[l] < 512) begin
                exp_bits[l][wr[l]] = frame_of(a, r, d);
                exp_cyc[l][wr[l]]  = cyc;
                wr[l]++;
            end
            remaining[l] = 12 * bc(l);
        end
    endtask

    task automatic scramble(int l);
        answer_v[l] = 5'($urandom);
        rem_v[l]    = 3'($urandom);
        is_div_v[l] = 1'($urandom);
    endtask

    task automatic send(int l, logic [4:0] a, logic [2:0] r, logic d);
        answer_v[l] = a;
        rem_v[l]    = r;
        is_div_v[l] = d;
        start_v[l]  = 1'b1;
        step(l);
        start_v[l]  = 1'b0;
        scramble(l);
        while (remaining[l] > 0) step(l);
        step(l);
    endtask

    task automatic run_lane(int l);
        reset_v[l] = 1'b1;
        start_v[l] = 1'b0;
        scramble(l);
        repeat (3) step(l);
        reset_v[l] = 1'b0;
        step(l);
        send(l, 5'b11101, 3'd2, 1'b1);
        send(l, 5'b10000, 3'd5, 1'b0);
        send(l, 5'd7, 3'b111, 1'b0);
        send(l, 5'b01111, 3'd1, 1'b1);
        send(l, 5'b00000, 3'd3, 1'b1);
        // start held high: back-to-back frames, mid-frame starts ignored
        start_v[l] = 1'b1;
        repeat (3 * (12 * bc(l) + 1) + 2) begin
            scramble(l);
            step(l);
        end
        start_v[l] = 1'b0;
        while (remaining[l] > 0) step(l);
        step(l);
        // reset during frame bit 5, then a clean frame
        scramble(l);
        start_v[l] = 1'b1;
        step(l);
        start_v[l] = 1'b0;
        repeat (5 * bc(l)) step(l);
        reset_v[l] = 1'b1;
        step(l);
        reset_v[l] = 1'b0;
        repeat (3) step(l);
        send(l, 5'b11101, 3'd2, 1'b1);
        repeat (400) begin
            scramble(l);
            start_v[l] = ($urandom_range(0, 3) == 0);
            reset_v[l] = ($urandom_range(0, 79) == 0);
            step(l);
        end
        start_v[l] = 1'b0;
        reset_v[l] = 1'b0;
        while (remaining[l] > 0) step(l);
        repeat (3) step(l);
        fin[l] = 1'b1;
    endtask

    logic in_frame[2];
    logic expect_done[2];
    int   nbits[2];
    int   cur[2];
    logic samp[2][64];

    task automatic finish_frame(int l);
        logic [11:0] got;
        logic        hold_ok;
        hold_ok = 1'b1;
        for (int k = 0; k < 12; k++) got[11-k] = samp[l][k*bc(l)];
        for (int i = 0; i < 12 * bc(l); i++)
            if (samp[l][i] !== samp[l][(i / bc(l)) * bc(l)]) hold_ok = 1'b0;
        if (cur[l] >= 0) chk(l, "frame_data", got, exp_bits[l][cur[l]]);
        chk(l, "bit_hold", hold_ok, 1);
        in_frame[l]    = 1'b0;
        expect_done[l] = 1'b1;
    endtask

    task automatic mon(int l);
        logic [3:0] outs;
        outs = {busy_v[l], ser_valid_v[l], ser_out_v[l], done_v[l]};
        if (rst_q[l] === 1'b1) begin
            chk(l, "reset_outputs", outs, 4'b0000);
            in_frame[l]    = 1'b0;
            expect_done[l] = 1'b0;
        end else if (expect_done[l]) begin
            chk(l, "done_pulse", outs, 4'b0001);
            expect_done[l] = 1'b0;
        end else if (in_frame[l]) begin
            chk(l, "frame_ctl", {busy_v[l], ser_valid_v[l], done_v[l]}, 3'b110);
            samp[l][nbits[l]] = ser_out_v[l];
            nbits[l]++;
            if (nbits[l] == 12 * bc(l)) finish_frame(l);
        end else if (ser_valid_v[l] === 1'b1) begin
            chk(l, "frame_ctl", {busy_v[l], ser_valid_v[l], done_v[l]}, 3'b110);
            chk(l, "frame_expected", 32'(rd[l] < wr[l]), 1);
            if (rd[l] < wr[l]) begin
                chk(l, "frame_start_cycle", cyc, exp_cyc[l][rd[l]]);
                cur[l] = rd[l];
                rd[l]++;
            end else begin
                cur[l] = -1;
            end
            in_frame[l] = 1'b1;
            samp[l][0]  = ser_out_v[l];
            nbits[l]    = 1;
        end else begin
            chk(l, "idle_outputs", outs, 4'b0000);
        end
    endtask

    always @(negedge clk) begin
        for (int l = 0; l < 2; l++) mon(l);
    end

    initial begin
        for (int l = 0; l < 2; l++) begin
            fin[l]         = 1'b0;
            wr[l]          = 0;
            rd[l]          = 0;
            remaining[l]   = 0;
            in_frame[l]    = 1'b0;
            expect_done[l] = 1'b0;
            nbits[l]       = 0;
            cur[l]         = -1;
        end
        fork
            run_lane(0);
            run_lane(1);
        join_none
        for (int i = 0; i < 30000 && !(fin[0] && fin[1]); i++) @(posedge clk);
        chk(0, "lanes_finished", {fin[0], fin[1]}, 2'b11);
        @(negedge clk);
        @(negedge clk);
        chk(0, "all_frames_seen", rd[0], wr[0]);
        chk(1, "all_frames_seen", rd[1], wr[1]);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
